multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Control unit for the multicycle RV32 datapath. It replaces the single-cycle decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles. It shares one memory port between instruction and data accesses, and waits on that port through a ready handshake. It also counts retired instructions and traps on illegal encodings.

Parameters:
ULACTRL_W, 3, width of ULAControl.
CNT_W, 32, width of retired-instruction counter.
ENABLE_JR, 1, 1 = decode opcode 1100111 (funct3 000) as JR; 0 = treat it as illegal.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
op  in  7  instr[6:0] from IR.
func3  in  3  instr[14:12].
func7  in  7  instr[31:25].
zero  in  1  ULA zero flag.
mem_ready  in  1  memory accepted/completed current access this cycle.
mem_req  out  1  memory access request.
MemWrite  out  1  store strobe; valid only while mem_req=1.
AdrSrc  out  1  0 = PC, 1 = ALUOut.
IRWrite  out  1  latch IR and OldPC.
PCWrite  out  1  PC load enable.
RegWrite  out  1  register file write.
ULASrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 reg.
ULASrcB  out  2  00 = rs2 reg, 01 = ImmExt, 10 = constant 4.
ULAControl  out  ULACTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt.
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J.
ResultSrc  out  2  00 ALUOut, 01 Data reg, 10 ULA result direct.
illegal  out  1  sticky trap flag.
retired  out  CNT_W  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JR, TRAP.
- Outputs are Moore, decoded from state plus latched IR fields. There is no output-side latency beyond the state.
- All outputs not listed for a state are 0. ImmSrc and ULA selects default to 00.
- Reset: state=FETCH, illegal=0, retired=0. All strobes are 0 while rst_n=0. An asserted reset aborts any pending access immediately.
- FETCH: mem_req=1, AdrSrc=0, ULASrcA=00, ULASrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ULASrcA=01, ULASrcB=01, ImmSrc=10, add (branch target into ALUOut). Next state by opcode/funct:
  - 0000011 f3=000 (LB) or 0100011 f3=000 (SB) -> MEMADR.
  - 0110011 with (f3,f7) in {000/0000000 ADD, 000/0100000 SUB, 111/0 AND, 110/0 OR, 010/0 SLT} -> EXECR.
  - 0010011 f3 in {000 ADDI, 111 ANDI, 110 ORI} -> EXECI.
  - 1100011 f3=000 -> BEQ.
  - 1101111 -> JAL.
  - 1100111 f3=000 with ENABLE_JR=1 -> JR.
  - Anything else -> TRAP.
- MEMADR: ULASrcA=10, ULASrcB=01, add. ImmSrc=00 for LB, 01 for SB. Next is MEMREAD for LB, MEMWRITE for SB.
- MEMREAD: mem_req=1, AdrSrc=1. Hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Hold until mem_ready, then FETCH.
- EXECR: ULASrcA=10, ULASrcB=00, ULAControl per funct (SUB when f7[5]=1, f3=000). Then ALUWB.
- EXECI: ULASrcA=10, ULASrcB=01, ImmSrc=00, ULAControl per f3. f7 is ignored. Then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ULASrcA=10, ULASrcB=00, sub, ResultSrc=00, PCWrite=zero. Then FETCH.
- JAL: ULASrcA=01, ULASrcB=10, add, ResultSrc=00, ImmSrc=11, PCWrite=1, RegWrite=1 (rd=OldPC+4, PC=target). Then FETCH.
  - DECODE for JAL uses ImmSrc=11 so that ALUOut holds the J target.
- JR: ULASrcA=10, ULASrcB=01, ImmSrc=00, add, ResultSrc=10, PCWrite=1, RegWrite=0. Then FETCH.
- TRAP: illegal=1, all strobes 0, terminal until reset. retired does not increment.
- retired increments by 1 on each transition into FETCH from MEMWB, MEMWRITE (on its mem_ready cycle), ALUWB, BEQ, JAL or JR. It wraps modulo 2^CNT_W.
- mem_ready is ignored in states where mem_req=0.
- mem_req and the address select stay stable until mem_ready.
- CPI: LB 5, SB 4, R/I 4, BEQ 3, JAL 3, JR 3 (each with zero wait states).

Test Plan:
- Reset mid-MEMREAD with mem_ready=0 -> next cycle state FETCH, mem_req=1, AdrSrc=0, retired=0, illegal=0.
- ADD x3,x1,x2 (0x002081B3), mem_ready always 1 -> 4 cycles. The ALUWB cycle has RegWrite=1, ResultSrc=00. retired goes 0 -> 1.
- SUB (func7=0100000) -> EXECR ULAControl=001. SLT -> 101. ANDI (f3=111, func7=0101010 garbage) -> 010, no trap.
- LB with mem_ready low for 3 cycles in MEMREAD -> mem_req=1, AdrSrc=1 held for 4 cycles, then MEMWB RegWrite=1, ResultSrc=01. Total 8 cycles.
- BEQ with zero=1 -> PCWrite=1 in BEQ state. With zero=0 -> PCWrite=0. Both take 3 cycles and retired increments.
- Opcode 0110111 (LUI), and JALR with ENABLE_JR=0 -> TRAP, illegal=1 held across 100 cycles, mem_req=0, retired unchanged until rst_n low.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control unit <-> datapath/memory signal bundle
interface multicycle_control_fsm_if #(
  parameter int ULACTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic [6:0]           op;
  logic [2:0]           func3;
  logic [6:0]           func7;
  logic                 zero;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 MemWrite;
  logic                 AdrSrc;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 RegWrite;
  logic [1:0]           ULASrcA;
  logic [1:0]           ULASrcB;
  logic [ULACTRL_W-1:0] ULAControl;
  logic [1:0]           ImmSrc;
  logic [1:0]           ResultSrc;
  logic                 illegal;
  logic [CNT_W-1:0]     retired;

  modport master (
    input  op, func3, func7, zero, mem_ready,
    output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ULASrcA, ULASrcB, ULAControl, ImmSrc, ResultSrc, illegal, retired
  );

  modport slave (
    output op, func3, func7, zero, mem_ready,
    input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
           ULASrcA, ULASrcB, ULAControl, ImmSrc, ResultSrc, illegal, retired
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore control FSM for the multicycle RV32 datapath
module multicycle_control_fsm #(
  parameter int ULACTRL_W = 3,
  parameter int CNT_W     = 32,
  parameter int ENABLE_JR = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_fsm_if.master  bus
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JR    = 7'b1100111;

  localparam logic [ULACTRL_W-1:0] ALU_ADD = ULACTRL_W'(3'b000);
  localparam logic [ULACTRL_W-1:0] ALU_SUB = ULACTRL_W'(3'b001);
  localparam logic [ULACTRL_W-1:0] ALU_AND = ULACTRL_W'(3'b010);
  localparam logic [ULACTRL_W-1:0] ALU_OR  = ULACTRL_W'(3'b011);
  localparam logic [ULACTRL_W-1:0] ALU_SLT = ULACTRL_W'(3'b101);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_JR, S_TRAP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_store;
  logic [ULACTRL_W-1:0]  r_alu_ctrl;
  logic [CNT_W-1:0]      r_retired;

  logic                  w_is_lb, w_is_sb, w_is_r, w_is_i, w_is_beq, w_is_jal, w_is_jr;
  logic [ULACTRL_W-1:0]  w_alu_ctrl;
  logic                  w_retire;
  logic                  w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write;
  logic [1:0]            w_src_a, w_src_b, w_imm_src, w_res_src;
  logic [ULACTRL_W-1:0]  w_ula_ctrl;

  // Instruction classification is only consumed in DECODE, where IR already holds the new word.
  always_comb begin
    w_is_lb  = (bus.op == OP_LOAD)  && (bus.func3 == 3'b000);
    w_is_sb  = (bus.op == OP_STORE) && (bus.func3 == 3'b000);
    w_is_r   = (bus.op == OP_R) &&
               (((bus.func3 == 3'b000) && ((bus.func7 == 7'b0000000) || (bus.func7 == 7'b0100000))) ||
                ((bus.func7 == 7'b0000000) &&
                 ((bus.func3 == 3'b111) || (bus.func3 == 3'b110) || (bus.func3 == 3'b010))));
    w_is_i   = (bus.op == OP_I) &&
               ((bus.func3 == 3'b000) || (bus.func3 == 3'b111) || (bus.func3 == 3'b110));
    w_is_beq = (bus.op == OP_BEQ) && (bus.func3 == 3'b000);
    w_is_jal = (bus.op == OP_JAL);
    w_is_jr  = (ENABLE_JR != 0) && (bus.op == OP_JR) && (bus.func3 == 3'b000);

    w_alu_ctrl = ALU_ADD;
    case (bus.func3)
      3'b000:  w_alu_ctrl = ((bus.op == OP_R) && bus.func7[5]) ? ALU_SUB : ALU_ADD;
      3'b111:  w_alu_ctrl = ALU_AND;
      3'b110:  w_alu_ctrl = ALU_OR;
      3'b010:  w_alu_ctrl = ALU_SLT;
      default: w_alu_ctrl = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_is_store <= 1'b0;
      r_alu_ctrl <= ALU_ADD;
      r_retired  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_is_store <= w_is_sb;
        r_alu_ctrl <= w_alu_ctrl;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_retire    = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_adr_src   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_src_a     = 2'b00;
    w_src_b     = 2'b00;
    w_imm_src   = 2'b00;
    w_res_src   = 2'b00;
    w_ula_ctrl  = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        w_src_b    = 2'b10;
        w_res_src  = 2'b10;
        w_ir_write = bus.mem_ready;
        w_pc_write = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // ALUOut captures the branch/jump target here for BEQ and JAL.
        w_src_a   = 2'b01;
        w_src_b   = 2'b01;
        w_imm_src = w_is_jal ? 2'b11 : 2'b10;
        if (w_is_lb || w_is_sb) w_next = S_MEMADR;
        else if (w_is_r)        w_next = S_EXECR;
        else if (w_is_i)        w_next = S_EXECI;
        else if (w_is_beq)      w_next = S_BEQ;
        else if (w_is_jal)      w_next = S_JAL;
        else if (w_is_jr)       w_next = S_JR;
        else                    w_next = S_TRAP;
      end
      S_MEMADR: begin
        w_src_a   = 2'b10;
        w_src_b   = 2'b01;
        w_imm_src = r_is_store ? 2'b01 : 2'b00;
        w_next    = r_is_store ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
        if (bus.mem_ready) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res_src   = 2'b01;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_EXECR: begin
        w_src_a    = 2'b10;
        w_ula_ctrl = r_alu_ctrl;
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a    = 2'b10;
        w_src_b    = 2'b01;
        w_ula_ctrl = r_alu_ctrl;
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_BEQ: begin
        w_src_a    = 2'b10;
        w_ula_ctrl = ALU_SUB;
        w_pc_write = bus.zero;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_JAL: begin
        w_src_a     = 2'b01;
        w_src_b     = 2'b10;
        w_imm_src   = 2'b11;
        w_pc_write  = 1'b1;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
        w_retire    = 1'b1;
      end
      S_JR: begin
        w_src_a    = 2'b10;
        w_src_b    = 2'b01;
        w_res_src  = 2'b10;
        w_pc_write = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Strobes are forced low for as long as reset is held, independent of the clock.
  assign bus.mem_req    = w_mem_req   & rst_n;
  assign bus.MemWrite   = w_mem_write & rst_n;
  assign bus.IRWrite    = w_ir_write  & rst_n;
  assign bus.PCWrite    = w_pc_write  & rst_n;
  assign bus.RegWrite   = w_reg_write & rst_n;
  assign bus.AdrSrc     = w_adr_src;
  assign bus.ULASrcA    = w_src_a;
  assign bus.ULASrcB    = w_src_b;
  assign bus.ULAControl = w_ula_ctrl;
  assign bus.ImmSrc     = w_imm_src;
  assign bus.ResultSrc  = w_res_src;
  assign bus.illegal    = (r_state == S_TRAP);
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - random + directed bench against a step-table model
module tb_multicycle_control_fsm;

  localparam int CNT_W = 32;

  localparam int K_LB = 0, K_SB = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_JR = 6, K_ILL = 7;
  localparam int P_F = 0, P_D = 1, P_A = 2, P_RD = 3, P_MWB = 4, P_WR = 5, P_XR = 6,
                 P_XI = 7, P_AWB = 8, P_B = 9, P_J = 10, P_JR = 11, P_T = 12;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] ctrl;
    logic [1:0] imm;
    logic [1:0] res;
    logic       ill;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst1_n;
  always #5 clk = ~clk;

  multicycle_control_fsm_if #(.ULACTRL_W(3), .CNT_W(CNT_W)) bus0 ();
  multicycle_control_fsm_if #(.ULACTRL_W(3), .CNT_W(CNT_W)) bus1 ();

  assign bus1.op        = bus0.op;
  assign bus1.func3     = bus0.func3;
  assign bus1.func7     = bus0.func7;
  assign bus1.zero      = bus0.zero;
  assign bus1.mem_ready = bus0.mem_ready;

  multicycle_control_fsm #(.ULACTRL_W(3), .CNT_W(CNT_W), .ENABLE_JR(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  multicycle_control_fsm #(.ULACTRL_W(3), .CNT_W(CNT_W), .ENABLE_JR(0)) dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1));

  outs_t act0;
  assign act0 = {bus0.mem_req, bus0.MemWrite, bus0.AdrSrc, bus0.IRWrite, bus0.PCWrite,
                 bus0.RegWrite, bus0.ULASrcA, bus0.ULASrcB, bus0.ULAControl, bus0.ImmSrc,
                 bus0.ResultSrc, bus0.illegal};

  int              n_chk = 0;
  int              n_pass = 0;
  int unsigned     m_retired = 0;
  outs_t           exp_o;
  logic [CNT_W-1:0] exp_ret;
  logic            chk_en = 1'b0;
  outs_t           seen [0:12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int classify(input logic [6:0] o, input logic [2:0] f3,
                                  input logic [6:0] f7, input bit jr_en);
    case (o)
      7'b0000011: return (f3 == 3'd0) ? K_LB : K_ILL;
      7'b0100011: return (f3 == 3'd0) ? K_SB : K_ILL;
      7'b0110011: begin
        if ((f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
            (f7 == 7'h00 && (f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2))) return K_R;
        return K_ILL;
      end
      7'b0010011: return (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6) ? K_I : K_ILL;
      7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_ILL;
      7'b1101111: return K_JAL;
      7'b1100111: return (f3 == 3'd0 && jr_en) ? K_JR : K_ILL;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_code(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    if (f3 == 3'd7) return 3'b010;
    if (f3 == 3'd6) return 3'b011;
    if (f3 == 3'd2) return 3'b101;
    if (o == 7'b0110011 && f7 == 7'h20) return 3'b001;
    return 3'b000;
  endfunction

  function automatic outs_t expect_outs(input int p, input logic [6:0] o, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic z, input logic rdy,
                                        input logic in_rst);
    outs_t e;
    e = '0;
    case (p)
      P_F:   begin e.mem_req = 1; e.src_b = 2'b10; e.res = 2'b10; e.ir_write = rdy; e.pc_write = rdy; end
      P_D:   begin e.src_a = 2'b01; e.src_b = 2'b01; e.imm = (o == 7'b1101111) ? 2'b11 : 2'b10; end
      P_A:   begin e.src_a = 2'b10; e.src_b = 2'b01; e.imm = (o == 7'b0100011) ? 2'b01 : 2'b00; end
      P_RD:  begin e.mem_req = 1; e.adr_src = 1; end
      P_MWB: begin e.res = 2'b01; e.reg_write = 1; end
      P_WR:  begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; end
      P_XR:  begin e.src_a = 2'b10; e.ctrl = alu_code(o, f3, f7); end
      P_XI:  begin e.src_a = 2'b10; e.src_b = 2'b01; e.ctrl = alu_code(o, f3, f7); end
      P_AWB: begin e.reg_write = 1; end
      P_B:   begin e.src_a = 2'b10; e.ctrl = 3'b001; e.pc_write = z; end
      P_J:   begin e.src_a = 2'b01; e.src_b = 2'b10; e.imm = 2'b11; e.pc_write = 1; e.reg_write = 1; end
      P_JR:  begin e.src_a = 2'b10; e.src_b = 2'b01; e.res = 2'b10; e.pc_write = 1; end
      P_T:   begin e.ill = 1; end
      default: e = '0;
    endcase
    if (in_rst) begin
      e.mem_req = 0; e.mem_write = 0; e.ir_write = 0; e.pc_write = 0; e.reg_write = 0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("outs", act0, exp_o);
      check("retired", bus0.retired, exp_ret);
    end
  end

  // One instruction from FETCH to its last step; waits < 0 means random mem_ready.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input int fetch_waits, input int mem_waits, input int zero_force,
                           input int trap_cycles, input int abort_at, output int cycles);
    int   steps[$];
    int   k, limit, waited;
    bit   waits, done;
    logic rdy;
    k = classify(o, f3, f7, 1'b1);
    steps.push_back(P_F);
    steps.push_back(P_D);
    case (k)
      K_LB:  begin steps.push_back(P_A); steps.push_back(P_RD); steps.push_back(P_MWB); end
      K_SB:  begin steps.push_back(P_A); steps.push_back(P_WR); end
      K_R:   begin steps.push_back(P_XR); steps.push_back(P_AWB); end
      K_I:   begin steps.push_back(P_XI); steps.push_back(P_AWB); end
      K_BEQ: steps.push_back(P_B);
      K_JAL: steps.push_back(P_J);
      K_JR:  steps.push_back(P_JR);
      default: for (int t = 0; t < trap_cycles; t++) steps.push_back(P_T);
    endcase
    cycles = 0;
    foreach (steps[i]) begin
      waits  = (steps[i] == P_F) || (steps[i] == P_RD) || (steps[i] == P_WR);
      limit  = (steps[i] == P_F) ? fetch_waits : mem_waits;
      waited = 0;
      done   = 0;
      while (!done) begin
        #1;
        bus0.op    = o;
        bus0.func3 = f3;
        bus0.func7 = f7;
        bus0.zero  = (zero_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zero_force);
        if (waits)
          rdy = (limit >= 0) ? (waited >= limit) : ((waited >= 8) || ($urandom_range(0, 2) != 0));
        else
          rdy = 1'($urandom_range(0, 1));
        bus0.mem_ready = rdy;
        exp_o   = expect_outs(steps[i], o, f3, f7, bus0.zero, rdy, 1'b0);
        exp_ret = CNT_W'(m_retired);
        chk_en  = 1'b1;
        @(negedge clk);
        seen[steps[i]] = act0;
        @(posedge clk);
        cycles++;
        if (abort_at > 0 && cycles == abort_at) return;
        done = !waits || rdy;
        waited++;
      end
    end
    if (k != K_ILL) m_retired++;
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    bus0.mem_ready = 1'b0;
    #1;
    check("rst_outs", act0, expect_outs(P_F, bus0.op, bus0.func3, bus0.func7, bus0.zero, 1'b0, 1'b1));
    check("rst_mem_req", bus0.mem_req, 64'd0);
    check("rst_illegal", bus0.illegal, 64'd0);
    check("rst_retired", bus0.retired, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_retired = 0;
    #1;
    check("post_rst_mem_req", bus0.mem_req, 64'd1);
    check("post_rst_adrsrc", bus0.AdrSrc, 64'd0);
    check("post_rst_illegal", bus0.illegal, 64'd0);
    @(posedge clk);
  endtask

  task automatic pick(output logic [6:0] o, output logic [2:0] f3, output logic [6:0] f7);
    int sel;
    sel = $urandom_range(0, 10);
    f3 = 3'd0;
    f7 = 7'd0;
    case (sel)
      0:  o = 7'b0000011;
      1:  o = 7'b0100011;
      2:  o = 7'b0110011;
      3:  begin o = 7'b0110011; f7 = 7'h20; end
      4:  begin o = 7'b0110011; f3 = 3'd7; end
      5:  begin o = 7'b0110011; f3 = 3'd6; end
      6:  begin o = 7'b0110011; f3 = 3'd2; end
      7:  begin
            o = 7'b0010011;
            f7 = 7'($urandom);
            case ($urandom_range(0, 2)) 0: f3 = 3'd0; 1: f3 = 3'd7; default: f3 = 3'd6; endcase
          end
      8:  o = 7'b1100011;
      9:  begin o = 7'b1101111; f3 = 3'($urandom); f7 = 7'($urandom); end
      default: o = 7'b1100111;
    endcase
  endtask

  initial begin
    int          cyc;
    int unsigned ret_before;
    logic [6:0]  o, f7;
    logic [2:0]  f3;
    rst_n = 1'b0;
    rst1_n = 1'b0;
    bus0.op = 7'd0; bus0.func3 = 3'd0; bus0.func7 = 7'd0; bus0.zero = 1'b0; bus0.mem_ready = 1'b0;
    do_reset();

    // ADD x3,x1,x2 = 0x002081B3
    run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, -1, 0, -1, cyc);
    check("add_cycles", 64'(cyc), 64'd4);
    check("add_awb_regwrite", seen[P_AWB].reg_write, 64'd1);
    check("add_awb_result", seen[P_AWB].res, 64'd0);
    #1 check("add_retired", bus0.retired, 64'd1);

    run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0, -1, 0, -1, cyc);
    check("sub_ctrl", seen[P_XR].ctrl, 64'b001);
    run_instr(7'b0110011, 3'b010, 7'b0000000, 0, 0, -1, 0, -1, cyc);
    check("slt_ctrl", seen[P_XR].ctrl, 64'b101);
    run_instr(7'b0010011, 3'b111, 7'b0101010, 0, 0, -1, 0, -1, cyc);
    check("andi_ctrl", seen[P_XI].ctrl, 64'b010);
    check("andi_no_trap", bus0.illegal, 64'd0);

    run_instr(7'b0000011, 3'b000, 7'd0, 0, 3, -1, 0, -1, cyc);
    check("lb_wait_cycles", 64'(cyc), 64'd8);
    check("lb_mwb_result", seen[P_MWB].res, 64'b01);
    run_instr(7'b0100011, 3'b000, 7'd0, 0, 0, -1, 0, -1, cyc);
    check("sb_cycles", 64'(cyc), 64'd4);
    run_instr(7'b1101111, 3'b000, 7'd0, 0, 0, -1, 0, -1, cyc);
    check("jal_cycles", 64'(cyc), 64'd3);

    run_instr(7'b1100011, 3'b000, 7'd0, 0, 0, 1, 0, -1, cyc);
    check("beq_taken_pcwrite", seen[P_B].pc_write, 64'd1);
    check("beq_taken_cycles", 64'(cyc), 64'd3);
    run_instr(7'b1100011, 3'b000, 7'd0, 0, 0, 0, 0, -1, cyc);
    check("beq_not_taken_pcwrite", seen[P_B].pc_write, 64'd0);
    check("beq_not_taken_cycles", 64'(cyc), 64'd3);
    #1 check("beq_retired", bus0.retired, 64'd9);

    // Reset while an LB is parked in MEMREAD with mem_ready low.
    run_instr(7'b0000011, 3'b000, 7'd0, 0, 100, -1, 0, 5, cyc);
    do_reset();

    for (int n = 0; n < 300; n++) begin
      pick(o, f3, f7);
      run_instr(o, f3, f7, -1, -1, -1, 0, -1, cyc);
    end

    // JALR: executes on the ENABLE_JR=1 unit, traps on the ENABLE_JR=0 unit.
    rst1_n = 1'b1;
    run_instr(7'b1100111, 3'b000, 7'd0, 0, 0, -1, 0, -1, cyc);
    check("jr_cycles", 64'(cyc), 64'd3);
    #1;
    check("nojr_illegal", bus1.illegal, 64'd1);
    check("nojr_mem_req", bus1.mem_req, 64'd0);
    check("nojr_retired", bus1.retired, 64'd0);

    // LUI opcode traps and stays trapped.
    ret_before = m_retired;
    run_instr(7'b0110111, 3'b000, 7'd0, 0, 0, -1, 100, -1, cyc);
    #1;
    check("lui_illegal", bus0.illegal, 64'd1);
    check("lui_retired_frozen", bus0.retired, 64'(ret_before));
    check("nojr_still_illegal", bus1.illegal, 64'd1);
    do_reset();

    run_instr(7'b0110011, 3'b110, 7'd0, 0, 0, -1, 0, -1, cyc);
    #1 check("after_trap_retired", bus0.retired, 64'd1);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
